keycode_packer: RTL

- Transmit-side counterpart of the keycode decoder: turns the six raw game buttons (up, left, down, right, Z-jump, X-shoot) into a packed 32-bit HID-style keycode word.
- The word carries four 8-bit slots, ordered by press time, and is delivered over a valid/ready handshake.
- Used as an on-board/test keyboard source feeding the same keycode bus the game logic consumes.
- Contains per-button debouncing, an ordered pressed-key list, HID rollover signalling and a two-state report FSM.

---
 rtl/keycode_packer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/keycode_packer.sv
// rtl/keycode_packer.sv - debounced six-button keycode packer with ordered slots and valid/ready report
module keycode_packer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        up_btn,
    input  logic        left_btn,
    input  logic        down_btn,
    input  logic        right_btn,
    input  logic        z_btn,
    input  logic        x_btn,
    input  logic        report_ready,
    output logic        report_valid,
    output logic [31:0] keycode,
    output logic        rollover
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int               NB       = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [31:0]      ROLL_KC  = 32'h0101_0101;

    logic [NB-1:0]    raw;
    logic [NB-1:0]    deb_q, deb_d;
    logic [NB-1:0]    deb_prev_q, deb_prev_d;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic [7:0]       list_q [NB];
    logic [7:0]       list_d [NB];
    logic             dirty_q, dirty_d;
    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [31:0]      kc_q, kc_d;
    logic             roll_q, roll_d;

    logic [NB-1:0]    rise, fall;
    logic             list_change;
    logic             overflow;
    logic [31:0]      snap_kc;
    logic [2:0]       n;
    logic             keep;

    // Bit order doubles as the append priority for simultaneous presses.
    assign raw = {x_btn, z_btn, right_btn, down_btn, left_btn, up_btn};

    function automatic logic [7:0] code_of(input int b);
        case (b)
            0:       code_of = 8'h52;
            1:       code_of = 8'h50;
            2:       code_of = 8'h51;
            3:       code_of = 8'h4F;
            4:       code_of = 8'h1D;
            5:       code_of = 8'h1B;
            default: code_of = 8'h00;
        endcase
    endfunction

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            deb_d[b] = deb_q[b];
            cnt_d[b] = '0;
            if (raw[b] != deb_q[b]) begin
                if (cnt_q[b] >= CNT_LAST) begin
                    deb_d[b] = raw[b];
                    cnt_d[b] = '0;
                end else if (cnt_q[b] != CNT_MAX) begin
                    cnt_d[b] = cnt_q[b] + CNT_ONE;
                end else begin
                    cnt_d[b] = cnt_q[b];
                end
            end
        end
        deb_prev_d = deb_q;
    end

    // Edges of the debounced state are consumed one cycle after they appear.
    assign rise        = deb_q & ~deb_prev_q;
    assign fall        = ~deb_q & deb_prev_q;
    assign list_change = |(rise | fall);

    always_comb begin
        n    = 3'd0;
        keep = 1'b0;
        for (int i = 0; i < NB; i++) begin
            list_d[i] = 8'h00;
        end
        for (int i = 0; i < NB; i++) begin
            keep = (list_q[i] != 8'h00);
            for (int b = 0; b < NB; b++) begin
                if (fall[b] && (list_q[i] == code_of(b))) begin
                    keep = 1'b0;
                end
            end
            if (keep && (n < 3'(NB))) begin
                list_d[n] = list_q[i];
                n         = n + 3'd1;
            end
        end
        for (int b = 0; b < NB; b++) begin
            if (rise[b] && (n < 3'(NB))) begin
                list_d[n] = code_of(b);
                n         = n + 3'd1;
            end
        end
    end

    // The list is compacted, so a fifth occupied entry means more than four keys.
    assign overflow = (list_q[4] != 8'h00);
    assign snap_kc  = overflow ? ROLL_KC : {list_q[3], list_q[2], list_q[1], list_q[0]};

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        kc_d    = kc_q;
        roll_d  = roll_q;
        dirty_d = dirty_q;
        case (state_q)
            IDLE: begin
                if (dirty_q) begin
                    kc_d    = snap_kc;
                    roll_d  = overflow;
                    valid_d = 1'b1;
                    dirty_d = 1'b0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (valid_q && report_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        if (list_change) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i]  <= '0;
                list_q[i] <= 8'h00;
            end
            dirty_q <= 1'b0;
            state_q <= IDLE;
            valid_q <= 1'b0;
            kc_q    <= 32'h0;
            roll_q  <= 1'b0;
        end else begin
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i]  <= cnt_d[i];
                list_q[i] <= list_d[i];
            end
            dirty_q <= dirty_d;
            state_q <= state_d;
            valid_q <= valid_d;
            kc_q    <= kc_d;
            roll_q  <= roll_d;
        end
    end

    assign report_valid = valid_q;
    assign keycode      = kc_q;
    assign rollover     = roll_q;

endmodule
